// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in, serial-out shift register.
// Accepts a word through a valid/ready handshake and sends it one bit per
// enabled clock. The bit order is chosen at load time. Back-to-back words
// follow with no idle cycle between them.
// Optional feature macro: PISO_PARITY_EN. When defined, an even-parity beat
// is appended after the data bits, so a frame is MSB+1 beats long.
module piso_shift_reg #(
    parameter int MSB = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           dir,
    input  logic           load_valid,
    input  logic [MSB-1:0] load_data,
    output logic           load_ready,
    output logic           sout,
    output logic           sout_valid,
    output logic           sout_last,
    output logic           busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = MSB + 1;
`else
    localparam int FRAME_LEN = MSB;
`endif

    // The counter only has to reach FRAME_LEN-1, and that value is at most MSB.
    localparam int CW = $clog2(MSB + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [MSB-1:0]  sreg_q, sreg_d;
    logic [CW-1:0]   count_q, count_d;
    logic            dir_q, dir_d;
    logic            lastBeat;
    logic            loadFire;
    logic            dataBit;
`ifdef PISO_PARITY_EN
    logic            parity_q, parity_d;
`endif

    // Select the outgoing bit from the held registers. It follows the bit
    // order captured at load, or the parity bit once all data bits are sent.
    always_comb begin
        dataBit = dir_q ? sreg_q[0] : sreg_q[MSB-1];
`ifdef PISO_PARITY_EN
        if (count_q == CW'(MSB)) begin
            dataBit = parity_q;
        end
`endif
    end

    // Flag the final beat of a frame and work out when a new word is taken.
    // A new word may be taken on the final beat, which keeps frames contiguous.
    always_comb begin
        lastBeat   = (state_q == SHIFT) && en && (count_q == LAST_IDX);
        load_ready = (state_q == IDLE) || lastBeat;
        loadFire   = load_valid && load_ready;
    end

    // Drive the serial outputs. They are gated to zero while idle, so a reset
    // or an idle link always presents a quiet line.
    always_comb begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_last  = 1'b0;
        busy       = 1'b0;
        if (state_q == SHIFT) begin
            busy       = 1'b1;
            sout       = dataBit;
            sout_valid = en;
            sout_last  = lastBeat;
        end
    end

    // Next-state logic. A load has priority over a shift because a load on the
    // last beat replaces the frame that is just ending. With en low, all state
    // holds, so a stalled beat is never consumed.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        count_d  = count_q;
        dir_d    = dir_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        if (loadFire) begin
            state_d  = SHIFT;
            sreg_d   = load_data;
            dir_d    = dir;
            count_d  = '0;
`ifdef PISO_PARITY_EN
            parity_d = ^load_data;
`endif
        end else if ((state_q == SHIFT) && en) begin
            if (dir_q) begin
                sreg_d = {1'b0, sreg_q[MSB-1:1]};
            end else begin
                sreg_d = {sreg_q[MSB-2:0], 1'b0};
            end
            if (lastBeat) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // State registers. Reset is asynchronous, so a reset during a frame
    // aborts it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: directed testbench for piso_shift_reg (MSB = 16).
// It captures every valid serial beat. It checks the bit sequence, rebuilds
// the word the way a receiving shift_reg would, and checks the position of
// each frame's last-beat flag.
module tb_piso_shift_reg;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 17;
`else
    localparam int FRAME = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic        load_ready;
    logic        sout;
    logic        sout_valid;
    logic        sout_last;
    logic        busy;

    int   testsRun = 0;
    int   testsFailed = 0;
    logic beatQ[$];
    int   lastQ[$];
    logic lastReady, lastSout, lastValid, lastBusy;
    int   readyCount;

    piso_shift_reg #(.MSB(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dir        (dir),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Compare one observed value against the expected one and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample the outputs
    // and record any valid beat.
    task automatic applyStimulus(input logic enV, input logic lvV, input logic [15:0] ldV, input logic dirV);
        @(negedge clk);
        en = enV;
        load_valid = lvV;
        load_data = ldV;
        dir = dirV;
        #1;
        lastReady = load_ready;
        lastSout  = sout;
        lastValid = sout_valid;
        lastBusy  = busy;
        if (sout_valid === 1'b1) begin
            beatQ.push_back(sout);
            if (sout_last === 1'b1) lastQ.push_back(beatQ.size());
        end else if (sout_last !== 1'b0) begin
            lastQ.push_back(-1);
        end
    endtask

    task automatic clearCapture();
        beatQ.delete();
        lastQ.delete();
    endtask

    // Return 16 captured beats in send order, with the first beat as the MSB.
    // This matches the word a dir=0 receiver would rebuild.
    function automatic logic [15:0] seqFrom(input int start);
        logic [15:0] w = '0;
        for (int i = 0; i < 16; i++) begin
            w = {w[14:0], (start + i < beatQ.size()) ? beatQ[start + i] : 1'bx};
        end
        return w;
    endfunction

    // Rebuild the word the way a dir=1 receiver would: shift right, fill at the MSB.
    function automatic logic [15:0] lsbRebuild(input int start);
        logic [15:0] w = '0;
        for (int i = 0; i < 16; i++) begin
            w = {(start + i < beatQ.size()) ? beatQ[start + i] : 1'bx, w[15:1]};
        end
        return w;
    endfunction

    function automatic logic beatAt(input int idx);
        return (idx < beatQ.size()) ? beatQ[idx] : 1'bx;
    endfunction

    // Load one word, run a full frame with en held high, then run one idle cycle.
    task automatic sendWord(input logic [15:0] word, input logic d);
        clearCapture();
        applyStimulus(1'b1, 1'b1, word, d);
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000, ~d);
            if (i == 0) checkOutput("first_beat_latency", beatQ.size(), 1);
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, d);
    endtask

    initial begin
        // Asynchronous reset with random inputs, checked before the first clock edge.
        #2;
        en = 1'($urandom);
        dir = 1'($urandom);
        load_valid = 1'($urandom);
        load_data = 16'($urandom);
        rst = 1'b1;
        #1;
        checkOutput("rst_sout", sout, 0);
        checkOutput("rst_sout_valid", sout_valid, 0);
        checkOutput("rst_sout_last", sout_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_load_ready", load_ready, 1);
        repeat (2) @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b0;

        // Send MSB first.
        sendWord(16'hA5C3, 1'b0);
        checkOutput("msb_beats", beatQ.size(), FRAME);
        checkOutput("msb_seq", seqFrom(0), 16'b1010010111000011);
        checkOutput("msb_last_cnt", lastQ.size(), 1);
        checkOutput("msb_last_pos", lastQ.size() > 0 ? lastQ[0] : -2, FRAME);
        checkOutput("msb_ready_after", lastReady, 1);
        checkOutput("msb_busy_after", lastBusy, 0);
`ifdef PISO_PARITY_EN
        checkOutput("parity_A5C3", beatAt(16), 0);
`endif

        // Send LSB first. dir toggles during the frame and must have no effect.
        sendWord(16'hA5C3, 1'b1);
        checkOutput("lsb_beats", beatQ.size(), FRAME);
        checkOutput("lsb_seq", seqFrom(0), 16'b1100001110100101);
        checkOutput("lsb_rebuild", lsbRebuild(0), 16'hA5C3);
        checkOutput("lsb_last_pos", lastQ.size() > 0 ? lastQ[0] : -2, FRAME);

        // Stall: drop en for 3 cycles after beat 5.
        clearCapture();
        applyStimulus(1'b1, 1'b1, 16'hF00F, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
            checkOutput("stall_valid", lastValid, 0);
            checkOutput("stall_sout_held", lastSout, 0);
            checkOutput("stall_busy", lastBusy, 1);
        end
        checkOutput("stall_beats_mid", beatQ.size(), 5);
        repeat (FRAME - 5) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("stall_beats", beatQ.size(), FRAME);
        checkOutput("stall_seq", seqFrom(0), 16'hF00F);
        checkOutput("stall_last_pos", lastQ.size() > 0 ? lastQ[0] : -2, FRAME);

        // Back-to-back: the second word waits and is taken on the last beat of the first.
        clearCapture();
        readyCount = 0;
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b0);
        for (int i = 1; i <= FRAME; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0001, 1'b0);
            if (i < FRAME && lastReady === 1'b1) readyCount++;
            if (i == FRAME) checkOutput("b2b_ready_last", lastReady, 1);
        end
        repeat (FRAME) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("b2b_ready_mid", readyCount, 0);
        checkOutput("b2b_beats", beatQ.size(), 2 * FRAME);
        checkOutput("b2b_word1", seqFrom(0), 16'hFFFF);
        checkOutput("b2b_word2", seqFrom(FRAME), 16'h0001);
        checkOutput("b2b_last_cnt", lastQ.size(), 2);
        checkOutput("b2b_last1", lastQ.size() > 0 ? lastQ[0] : -2, FRAME);
        checkOutput("b2b_last2", lastQ.size() > 1 ? lastQ[1] : -2, 2 * FRAME);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("b2b_idle_after", lastBusy, 0);

        // Abort with a mid-frame reset, then send a clean frame.
        clearCapture();
        applyStimulus(1'b1, 1'b1, 16'hA5C3, 1'b0);
        repeat (8) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_valid", sout_valid, 0);
        checkOutput("abort_sout", sout, 0);
        checkOutput("abort_ready", load_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        sendWord(16'h8001, 1'b0);
        checkOutput("post_abort_beats", beatQ.size(), FRAME);
        checkOutput("post_abort_seq", seqFrom(0), 16'b1000000000000001);
        checkOutput("post_abort_last", lastQ.size() > 0 ? lastQ[0] : -2, FRAME);

`ifdef PISO_PARITY_EN
        // A word with an odd number of ones carries a parity bit of 1.
        sendWord(16'hA5C2, 1'b0);
        checkOutput("parity_A5C2", beatAt(16), 1);
        checkOutput("parity_A5C2_beats", beatQ.size(), 17);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
